// File: rtl/exec_pkg.sv
// Shared types for the integer execute unit: operation codes, FSM states and
// the alu_op encodings driven by the main decoder.
package exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } exec_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } exec_state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

endpackage

// File: rtl/div_iter.sv
// Restoring divider core: strips operand signs on start, runs XLEN shift/subtract
// iterations and presents sign-corrected quotient and remainder once done.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dsr_q;
  logic            q_neg_q, r_neg_q;

  logic            a_neg, b_neg, ge;
  logic [XLEN:0]   shifted, diff;

  assign a_neg   = is_signed & dividend[XLEN-1];
  assign b_neg   = is_signed & divisor[XLEN-1];
  // Dividend bits enter the partial remainder MSB-first through quo_q.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign ge      = shifted >= {1'b0, dsr_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (kill) begin
      active_q <= 1'b0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      quo_q    <= a_neg ? -dividend : dividend;
      rem_q    <= '0;
      dsr_q    <= b_neg ? -divisor : divisor;
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
    end else if (active_q) begin
      quo_q <= {quo_q[XLEN-2:0], ge};
      rem_q <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

  assign done      = active_q && (cnt_q == CW'(XLEN - 1));
  assign quotient  = q_neg_q ? -quo_q : quo_q;
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exec_unit.sv
// Integer execute unit: ALU-op decode, ALU, multiplier and iterative divider
// behind a valid/ready handshake with a single-entry result register.
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            is_rtype,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int              SHW     = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  exec_op_t        op;
  exec_state_t     state_q, state_d;
  logic            accept, is_div, is_rem, div_signed, div_zero, div_ovf, div_iterate;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] mul_lo, mul_hi, div_quo, div_rem, fast_res;
  logic            div_done, rem_sel_q, out_valid_q;
  logic [XLEN-1:0] out_result_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    op = OP_ADD;
    unique case (alu_op)
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        if (is_rtype && funct7b0) begin
          if (ENABLE_M) op = exec_op_t'(5'd10 + {2'b00, funct3});
        end else begin
          unique case (funct3)
            3'b000:  op = (is_rtype && funct7b5) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ADD;
    endcase
  end

  assign shamt       = op_b[SHW-1:0];
  assign is_div      = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_rem      = op inside {OP_REM, OP_REMU};
  assign div_signed  = op inside {OP_DIV, OP_REM};
  assign div_zero    = (op_b == '0);
  assign div_ovf     = div_signed && (op_a == MIN_NEG) && (op_b == '1);
  assign div_iterate = is_div && !div_zero && !div_ovf;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Divide special cases resolve here: divisor 0 and the MIN/-1 overflow.
  always_comb begin
    fast_res = '0;
    case (op)
      OP_ADD:    fast_res = op_a + op_b;
      OP_SUB:    fast_res = op_a - op_b;
      OP_AND:    fast_res = op_a & op_b;
      OP_OR:     fast_res = op_a | op_b;
      OP_XOR:    fast_res = op_a ^ op_b;
      OP_SLT:    fast_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   fast_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_SLL:    fast_res = op_a << shamt;
      OP_SRL:    fast_res = op_a >> shamt;
      OP_SRA:    fast_res = $signed(op_a) >>> shamt;
      OP_MUL:    fast_res = mul_lo;
      OP_MULH, OP_MULHSU, OP_MULHU: fast_res = mul_hi;
      OP_DIV, OP_DIVU: fast_res = div_zero ? '1 : op_a;
      OP_REM, OP_REMU: fast_res = div_zero ? op_a : '0;
      default:   fast_res = '0;
    endcase
  end

  if (ENABLE_M) begin : g_m
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;

    // Extending straight to 2*XLEN gives the same low 2*XLEN product bits as
    // the signed (XLEN+1)-bit form.
    assign a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_sgn = (op == OP_MULH);
    assign a_ext = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
    assign b_ext = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
    assign prod  = a_ext * b_ext;
    assign mul_lo = prod[XLEN-1:0];
    assign mul_hi = prod[2*XLEN-1:XLEN];

    div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept && div_iterate),
      .kill      (flush),
      .is_signed (div_signed),
      .dividend  (op_a),
      .divisor   (op_b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
    );
  end else begin : g_no_m
    assign mul_lo   = '0;
    assign mul_hi   = '0;
    assign div_quo  = '0;
    assign div_rem  = '0;
    assign div_done = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && div_iterate) state_d = S_DIV;
        S_DIV:   if (div_done) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

  // Acceptance needs a free (or draining) slot, so a load never overwrites
  // an unconsumed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      rem_sel_q    <= 1'b0;
    end else begin
      if (accept && div_iterate) rem_sel_q <= is_rem;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept && !div_iterate) begin
        out_valid_q  <= 1'b1;
        out_result_q <= fast_res;
      end else if (state_q == S_FIX) begin
        out_valid_q  <= 1'b1;
        out_result_q <= rem_sel_q ? div_rem : div_quo;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: expected results are queued on acceptance
// and compared when the DUT hands a result over.
module tb_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic            funct7b5 = 1'b0;
  logic            funct7b0 = 1'b0;
  logic            is_rtype = 1'b0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic            busy;

  exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .funct7b0   (funct7b0),
    .is_rtype   (is_rtype),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_pass = 0;
  int        n_total = 0;
  int        stalls_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Offers one op and waits (bounded) for acceptance; the expectation joins
  // the scoreboard on the accepting edge.
  task automatic send(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                      input logic rt, input logic f5, input logic f0,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] exp, output int stalls);
    logic      acc;
    sb_entry_t e;
    stalls   = 0;
    alu_op   = aop;
    funct3   = f3;
    is_rtype = rt;
    funct7b5 = f5;
    funct7b0 = f0;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      stalls++;
      if (stalls > 200) begin
        check({tag, "_accept_timeout"}, acc, 1'b1);
        break;
      end
    end
    if (acc) begin
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'(sb_q.size()), 64'd1);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check(e.tag, out_result, e.exp);
      end
    end
  end

  initial begin
    int st;
    int lat;
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // ADD held while the consumer stalls
    send("add_hold", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, st);
    check("add_lat1", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", out_result, 32'd12);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Back-to-back single-cycle ops
    send("addi",  2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd10, 32'd3, 32'd13, st); stalls_total += st;
    send("srai",  2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, st); stalls_total += st;
    send("sub_r", 2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd10, 32'd3, 32'd7, st); stalls_total += st;
    send("sub_op", 2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 32'd20, 32'd25, 32'hFFFF_FFFB, st); stalls_total += st;
    send("and",   2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, st); stalls_total += st;
    send("or",    2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, st); stalls_total += st;
    send("xor",   2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, st); stalls_total += st;
    send("slt",   2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, st); stalls_total += st;
    send("sltu",  2'b10, 3'b011, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, st); stalls_total += st;
    send("sll",   2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 32'd1, 32'h0000_003F, 32'h8000_0000, st); stalls_total += st;
    send("srl",   2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, st); stalls_total += st;
    send("add11", 2'b11, 3'b010, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4, 32'd7, st); stalls_total += st;
    send("mul",   2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, st); stalls_total += st;
    send("mulh",  2'b10, 3'b001, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, st); stalls_total += st;
    send("mulhsu", 2'b10, 3'b010, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, st); stalls_total += st;
    send("mulhu", 2'b10, 3'b011, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, st); stalls_total += st;
    send("div_ovf", 2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, st); stalls_total += st;
    check("div_ovf_lat1", out_valid, 1'b1);
    check("div_ovf_busy", busy, 1'b0);
    send("rem_ovf", 2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, st); stalls_total += st;
    send("divu_z", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, st); stalls_total += st;
    send("div_z",  2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, st); stalls_total += st;
    send("remu_z", 2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 32'd9, 32'd0, 32'd9, st); stalls_total += st;
    check("b2b_stalls", 64'(stalls_total), 64'd0);

    // Iterative divides
    send("divu", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, st);
    check("divu_busy", busy, 1'b1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("divu_latency", 64'(lat), 64'd34);
    send("rem_neg",  2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, st);
    send("div_neg",  2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, st);
    send("div_nb",   2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, st);
    send("rem_nb",   2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, st);
    send("remu",     2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, st);
    send("divu_big", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, st);

    // Flush part-way through a divide
    send("divu_flushed", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'd1000, 32'd3, 32'd333, st);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_busy", busy, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    send("add_after_flush", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, st);
    check("flush_add_stalls", 64'(st), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 1'b0);

    // Asynchronous reset in the middle of a divide
    @(posedge clk);
    #1;
    send("div_reset", 2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'd1000, 32'd3, 32'd333, st);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("arst_busy", busy, 1'b0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", in_ready, 1'b1);

    // Drain
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised integer execute unit for the RV32I/RV32M core: it merges ALU-op decode, ALU, multiplier and an iterative divider behind a valid/ready handshake. It sits between the ID/EX register and the writeback path and replaces the combinational decode-plus-ALU path. M-extension ops are enabled by parameter. A single-entry output register holds each result until it is consumed.

## Interface
- `XLEN`, 32: operand/result width (32 or 64).
- `ENABLE_M`, 1: 1 = MUL/DIV/REM families implemented; 0 = M ops decode as ADD.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous kill of in-flight op and held result.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `alu_op`  in  2  00 = ADD, 01 = SUB, 10 = funct decode, 11 = ADD.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `funct7b0`  in  1  instr[25]; selects M ops when R-type.
- `is_rtype`  in  1  1 = register-register instruction.
- `op_a`, `op_b`  in  XLEN  operands.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  XLEN  result.
- `busy`  out  1  divider iterating.

## Operation
- Decode, with alu_op = 10:
  - funct3 000: SUB only if is_rtype & funct7b5; ADDI always ADD.
  - funct3 101: SRA if funct7b5, else SRL. This applies to both R- and I-type.
  - Other funct3 values decode as AND/OR/XOR/SLT/SLTU/SLL, per the RV32I encodings.
- M-op select: is_rtype & funct7b0 & ENABLE_M. funct3 then selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
- Shift amount is op_b[$clog2(XLEN)-1:0]. SLT/SLTU results are zero-extended to XLEN.
- Handshake:
  - Accept on in_valid & in_ready.
  - in_ready = (state == IDLE) & (!out_valid | out_ready).
  - out_valid stays high with out_result stable until out_ready.
- States:
  - IDLE
    - accept non-divide op: go to IDLE, result loaded into the output register.
    - accept divide op, special case: go to IDLE, result loaded directly.
    - accept divide op, normal case: go to DIV.
  - DIV: sign-strip and load, then XLEN restoring iterations, counter 0..XLEN-1; go to FIX when the count reaches XLEN-1.
  - FIX: apply quotient/remainder sign, load the output register, go to IDLE.
- Divide special cases:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a.
  - DIV of −2^(XLEN−1) by −1: quotient is −2^(XLEN−1), remainder is 0.
- Sign rules: REM takes the sign of the dividend; MULH/MULHSU/MULHU return the upper XLEN bits of the 2·XLEN product.
- flush:
  - Forces IDLE and clears out_valid and busy the next edge.
  - Takes priority over acceptance and completion in the same cycle.
  - in_ready is 0 during the flush cycle.

## Timing
- Reset values: out_valid=0, out_result=0, busy=0, state=IDLE. in_ready=1 once rst_n is high.
- ALU, MUL and divide special cases: out_valid rises on the edge after acceptance, so latency is 1.
- Normal divide: latency XLEN+2 (load, XLEN iterations, FIX). That is 34 cycles at XLEN=32.
- busy is high while state is DIV or FIX.
- Back-to-back single-cycle ops sustain 1 op/cycle when out_ready=1.
- Completion with out_valid already high cannot occur, because acceptance requires the slot to be free.
- Reset asserted mid-divide returns all outputs to reset values asynchronously.

## Structure
- `exec_pkg`:
  - 5-bit `exec_op_t` enum: the ten ALU codes keep values 0–9 (ADD=0…SRA=9); MUL…REMU are 10–17.
  - state enum.
  - alu_op encodings.
- Sub-module `div_iter`: XLEN-parametrised restoring divider core with start, done, signed flag, quotient and remainder. It is instantiated only when ENABLE_M=1.
- Multiplier: inferred `*` on (XLEN+1)-bit sign/zero-extended operands.

## Test plan
- Reset, then ADD 5+7 with out_ready=0 for 3 cycles → out_result=12 held; in_ready=0 until release.
- ADDI (alu_op=10, is_rtype=0, funct7b5=1), 10, 3 → 13. SRAI 0x80000000 by 4 → 0xF8000000.
- DIVU 100/7 → 14 with out_valid exactly 34 cycles after acceptance; REM −7/2 → −1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at latency 1. DIVU x/0 → 0xFFFFFFFF. REMU 9/0 → 9.
- MULH 0x80000000·0x80000000 → 0x40000000. MULHSU −1·2 → 0xFFFFFFFF.
- flush at iteration 10 of a divide → out_valid never rises, busy=0 next cycle; a following ADD accepted immediately.
